// File: rtl/sram_arbiter.sv
// Two-master SRAM-style arbiter: data master (m0) and inst master (m1) share one slave port.
// Zero-latency combinational grant, in-order response routing via a 1-bit ID FIFO.
module sram_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        resetn,
  // data master
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [2:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  // inst master
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  output logic [31:0] m1_rdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  // slave
  output logic        s_req,
  output logic        s_wr,
  output logic [2:0]  s_size,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  output logic        err_orphan
);

  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned STARVE_W = 8;

  logic [DEPTH-1:0]    ids_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                err_orphan_q;

  logic force_inst_c, full_c, empty_c;
  logic gnt_m0_c, gnt_m1_c;
  logic push_c, pop_c, head_c;

  assign force_inst_c = (starve_q == STARVE_W'(STARVE_LIMIT)) && m1_req;
  assign full_c       = (cnt_q == CNT_W'(DEPTH));
  assign empty_c      = (cnt_q == '0);

  assign gnt_m0_c = m0_req && !force_inst_c;
  assign gnt_m1_c = !gnt_m0_c && m1_req;

  // Request path: gated by reset and by FIFO space, no buffering.
  assign s_req      = resetn && !full_c && (gnt_m0_c || gnt_m1_c);
  assign m0_addr_ok = s_req && gnt_m0_c && s_addr_ok;
  assign m1_addr_ok = s_req && gnt_m1_c && s_addr_ok;

  assign s_wr    = gnt_m0_c ? m0_wr    : 1'b0;
  assign s_size  = gnt_m0_c ? m0_size  : 3'd2;
  assign s_addr  = gnt_m0_c ? m0_addr  : m1_addr;
  assign s_wdata = gnt_m0_c ? m0_wdata : 32'd0;
  assign s_wstrb = gnt_m0_c ? m0_wstrb : 4'd0;

  // Response path: head ID of the order FIFO selects which master sees data_ok.
  assign push_c  = s_req && s_addr_ok;
  assign pop_c   = resetn && s_data_ok && !empty_c;
  assign head_c  = ids_q[rd_ptr_q];

  assign m0_data_ok = pop_c && !head_c;
  assign m1_data_ok = pop_c && head_c;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;
  assign err_orphan = err_orphan_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push_c && !pop_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_c && !push_c) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Starvation counter: counts m0 wins while m1 waits, saturating at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!m1_req || m1_addr_ok) begin
      starve_d = '0;
    end else if (m0_addr_ok && (starve_q < STARVE_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ids_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      starve_q     <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      if (push_c) begin
        ids_q[wr_ptr_q] <= gnt_m1_c;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      if (s_data_ok && empty_c) begin
        err_orphan_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the maximum number of outstanding slave transactions; it SHALL be a power of 2 and at least 2.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, meaning the number of consecutive data grants allowed while inst is waiting; range 1..255.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 m0_req, m0_wr  in  1 each  data master request and write flag.
REQ-006 m0_size  in  3  data master transfer size; m0_addr, m0_wdata  in  32 each; m0_wstrb  in  4.
REQ-007 m0_rdata  out  32; m0_addr_ok, m0_data_ok  out  1 each  data master returns.
REQ-008 m1_req  in  1; m1_addr  in  32  inst master, read-only, implied size 3'd2; m1_rdata  out  32; m1_addr_ok, m1_data_ok  out  1 each.
REQ-009 s_req, s_wr  out  1 each; s_size  out  3; s_addr, s_wdata  out  32 each; s_wstrb  out  4  slave request toward the AXI bridge.
REQ-010 s_rdata  in  32; s_addr_ok, s_data_ok  in  1 each  slave returns, data_ok in request-accept order.
REQ-011 err_orphan  out  1  sticky flag: a data_ok arrived with no outstanding entry.

Function
REQ-012 Handshake: a request SHALL be accepted in a cycle where s_req=1 and s_addr_ok=1; exactly one master's addr_ok SHALL equal s_addr_ok in that cycle, and the other SHALL be 0.
REQ-013 Grant SHALL be combinational per cycle: m0 wins if m0_req=1 and not in force-inst mode; otherwise m1 wins if m1_req=1.
REQ-014 s_req SHALL be 0 whenever the order FIFO holds DEPTH entries; both addr_ok outputs SHALL then be 0.
REQ-015 Slave fields SHALL mux from the granted master; for an m1 grant: s_wr=0, s_size=2, s_wstrb=0, s_wdata=0.
REQ-016 Order FIFO SHALL push the 1-bit grant ID on each accept and pop on each s_data_ok while non-empty; simultaneous push and pop SHALL leave the count unchanged, including when the FIFO is full (pop frees the slot only on the next cycle per REQ-014).
REQ-017 Read and write pointers SHALL wrap modulo DEPTH; the count SHALL be DEPTH+1 wide-safe (0..DEPTH).
REQ-018 On s_data_ok, the FIFO head ID SHALL route the response: mX_data_ok=1 for the head master only, in the same cycle, combinationally; mX_rdata=s_rdata for both masters at all times.
REQ-019 s_data_ok while FIFO empty SHALL assert no master data_ok, leave the FIFO unchanged and set err_orphan=1 until reset.
REQ-020 Starvation counter (8 bit): increments on each m0 accept while m1_req=1; clears on any m1 accept or when m1_req=0; saturates at STARVE_LIMIT.
REQ-021 Force-inst mode SHALL be active while counter==STARVE_LIMIT and m1_req=1; m1 gets the next accept, then the counter clears.
REQ-022 Latency: arbiter SHALL add zero cycles on request and response paths; no request buffering.

Reset
REQ-023 During resetn=0: FIFO empty, pointers 0, starve counter 0, err_orphan=0; s_req, all addr_ok/data_ok SHALL be 0 regardless of inputs.
REQ-024 Reset asserted mid-transaction SHALL discard all outstanding entries; late s_data_ok after release SHALL set err_orphan per REQ-019.

Verification
REQ-025 m0 and m1 both request with s_addr_ok=1 every cycle -> m0_addr_ok=1, m1_addr_ok=0; after 8 m0 accepts, the 9th accept goes to m1.
REQ-026 Four m1 accepts with no data_ok (DEPTH=4) -> s_req=0, m1_addr_ok=0 on the 5th cycle; one s_data_ok -> m1_data_ok=1, with s_req=1 in the following cycle.
REQ-027 Accept order m0, m1, m0, then three s_data_ok with rdata 0xA,0xB,0xC -> m0 gets 0xA, m1 gets 0xB, m0 gets 0xC.
REQ-028 FIFO at 3 entries, simultaneous accept and s_data_ok -> count stays at 3 and head routing is correct.
REQ-029 s_data_ok pulse with an empty FIFO -> no master data_ok, and err_orphan=1 held until resetn=0.
REQ-030 resetn pulsed low with 2 outstanding entries -> all outputs 0 immediately; after release, the first m1 request is accepted with FIFO count 1.
